// File: rtl/apb_master_nslave_pkg.sv
// Shared types and helpers for the N-slave APB3 master bridge.
// State encoding, default widths, slave-index decode and one-hot expansion.
package apb_nslave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned DEF_ADDR_W     = 9;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_NUM_SLAVES = 2;
    localparam int unsigned DEF_TIMEOUT    = 16;
    localparam int unsigned MAX_SLAVES     = 16;
    localparam int unsigned MAX_SEL_W      = 4;

    // Top sel_w bits of an addr_w-bit address, zero-extended to MAX_SEL_W.
    function automatic logic [MAX_SEL_W-1:0] sel_idx(input logic [63:0] addr,
                                                     input int unsigned addr_w,
                                                     input int unsigned sel_w);
        return MAX_SEL_W'(addr >> (addr_w - sel_w)) &
               ((MAX_SEL_W'(1) << sel_w) - MAX_SEL_W'(1));
    endfunction

    function automatic logic [MAX_SLAVES-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        return MAX_SLAVES'(1) << idx;
    endfunction

endpackage

// File: rtl/apb_master_nslave_if.sv
// Command/response handshake plus APB fabric signals of the bridge.
// master modport is the bridge's view; slave modport is the command source/fabric view.
interface apb_master_nslave_if
    import apb_nslave_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [DATA_W-1:0]            cmd_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_master_nslave_slave_mux.sv
// Combinational NUM_SLAVES:1 selector for the response side of the APB fabric.
module apb_slave_mux #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned SEL_W      = 1
) (
    input  logic [SEL_W-1:0]             idx_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]        pready_i,
    input  logic [NUM_SLAVES-1:0]        pslverr_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         ready_o,
    output logic                         err_o
);

    // Out-of-range indices select nothing and yield zeros.
    always_comb begin
        rdata_o = '0;
        ready_o = 1'b0;
        err_o   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_i == SEL_W'(i)) begin
                rdata_o = prdata_i[i*DATA_W +: DATA_W];
                ready_o = pready_i[i];
                err_o   = pslverr_i[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_nslave.sv
// APB3 master bridge: single-beat command/response to SETUP/ACCESS on NUM_SLAVES slaves.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_nslave
    import apb_nslave_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input logic                pclk,
    input logic                preset,
    apb_master_nslave_if.master bus
);

    localparam int unsigned SEL_W = $clog2(NUM_SLAVES);

    if (NUM_SLAVES < 2 || NUM_SLAVES > MAX_SLAVES || TIMEOUT == 0) begin : g_cfg_check
        $error("apb_master_nslave: unsupported NUM_SLAVES/TIMEOUT");
    end

    state_e                state_q,     state_d;
    logic [SEL_W-1:0]      idx_q,       idx_d;
    logic [NUM_SLAVES-1:0] psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]     paddr_q,     paddr_d;
    logic [DATA_W-1:0]     pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic [SEL_W-1:0]      cmd_idx;
    logic                  cmd_hit;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  sel_ready;
    logic                  sel_err;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]      tmo_q, tmo_d;
`endif

    assign cmd_idx = SEL_W'(sel_idx(64'(bus.cmd_addr), ADDR_W, SEL_W));
    assign cmd_hit = 32'(cmd_idx) < NUM_SLAVES;

    apb_slave_mux #(
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_mux (
        .idx_i     (idx_q),
        .prdata_i  (bus.prdata),
        .pready_i  (bus.pready),
        .pslverr_i (bus.pslverr),
        .rdata_o   (sel_rdata),
        .ready_o   (sel_ready),
        .err_o     (sel_err)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    idx_d    = cmd_idx;
                    if (cmd_hit) begin
                        psel_d  = NUM_SLAVES'(onehot(MAX_SEL_W'(cmd_idx)));
                        state_d = SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout expiring in the same cycle.
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (pwrite_q || sel_err) ? '0 : sel_rdata;
                    state_d     = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Bench for apb_master_nslave: 2-slave/9-bit instance with a slave model and
// scoreboard, plus a 3-slave/10-bit instance for decode errors.
module tb_apb_master_nslave;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         lat;
        int         t;
    } exp_t;

    logic pclk;
    logic preset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t sb[$];
    exp_t sb3[$];

    // Slave model configuration for the transfer in flight.
    int         cfg_waits = 0;
    logic       cfg_err = 1'b0;
    logic [7:0] cfg_rdata = 8'h00;
    logic [1:0] exp_psel = 2'b00;
    logic [8:0] exp_addr = '0;
    logic       exp_write = 1'b0;
    logic [7:0] exp_wdata = '0;
    logic       dec_active = 1'b0;

    int         acc_cnt = 0;
    logic [8:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       have_wr = 1'b0;

    apb_master_nslave_if #(.ADDR_W(9),  .DATA_W(8), .NUM_SLAVES(2)) bus ();
    apb_master_nslave_if #(.ADDR_W(10), .DATA_W(8), .NUM_SLAVES(3)) bus3 ();

    apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT(4)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    apb_master_nslave #(.ADDR_W(10), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(4)) dut3 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Unselected slaves answer ready+error with junk data, which must be ignored.
    always_comb begin
        bus.pready  = '1;
        bus.pslverr = '1;
        bus.prdata  = {8'h5A, 8'h5A};
        for (int i = 0; i < 2; i++) begin
            if (bus.psel[i]) begin
                bus.pready[i]          = bus.penable && (acc_cnt >= cfg_waits);
                bus.pslverr[i]         = cfg_err;
                bus.prdata[i*8 +: 8]   = (have_wr && bus.paddr == wr_addr) ? wr_data : cfg_rdata;
            end
        end
    end

    assign bus3.pready  = '1;
    assign bus3.pslverr = '0;
    assign bus3.prdata  = {8'h11, 8'h22, 8'h33};

    always @(posedge pclk) begin
        acc_cnt <= bus.penable ? acc_cnt + 1 : 0;
        if (bus.penable && |(bus.psel & bus.pready) && bus.pwrite && !cfg_err) begin
            wr_addr <= bus.paddr;
            wr_data <= bus.pwdata;
            have_wr <= 1'b1;
        end
    end

    always @(negedge pclk) begin : mon
        exp_t e;
        logic sel_seen;
        logic chk_rdy;
        if (preset) begin
            if (chk_rdy) begin
                chk("ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
                chk_rdy = 1'b0;
            end
            if (bus.psel != '0) begin
                if (!sel_seen) chk("setup_penable", 32'(bus.penable), 32'd0);
                chk("psel", 32'(bus.psel), 32'(exp_psel));
                chk("paddr", 32'(bus.paddr), 32'(exp_addr));
                chk("pwrite", 32'(bus.pwrite), 32'(exp_write));
                chk("pwdata", 32'(bus.pwdata), 32'(exp_wdata));
                chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            end
            sel_seen = (bus.psel != '0);
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rd));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.t + 1), 32'(e.lat));
                    chk_rdy = 1'b1;
                end
            end
        end else begin
            sel_seen = 1'b0;
            chk_rdy  = 1'b0;
        end
    end

    always @(negedge pclk) begin : mon3
        exp_t e;
        if (preset) begin
            if (dec_active) chk("dec_psel", 32'(bus3.psel), 32'd0);
            if (bus3.rsp_valid) begin
                if (sb3.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp3: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb3.pop_front();
                    chk("dec_rdata", 32'(bus3.rsp_rdata), 32'(e.rd));
                    chk("dec_err", 32'(bus3.rsp_err), 32'(e.err));
                    chk("dec_latency", 32'(cyc - e.t + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                         input int waits, input logic serr, input logic [7:0] sdata,
                         input logic push, input logic [7:0] exp_rd, input logic exp_err,
                         input int exp_lat);
        int guard;
        @(negedge pclk);
        cfg_waits     = waits;
        cfg_err       = serr;
        cfg_rdata     = sdata;
        exp_psel      = addr[8] ? 2'b10 : 2'b01;
        exp_addr      = addr;
        exp_write     = wr;
        exp_wdata     = wd;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end
        if (push) sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat, t: cyc + 1});
        @(posedge pclk);
        #1 bus.cmd_valid = 1'b0;
        if (push) begin
            guard = 0;
            while (sb.size() != 0 && guard < 100) begin
                @(negedge pclk);
                guard++;
            end
            if (sb.size() != 0) begin
                total++;
                bad++;
                $display("FAIL rsp_timeout: got no rsp_valid expected one within 100 cycles");
                sb.delete();
            end
        end
    endtask

    initial begin
        int guard;
        preset         = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus3.cmd_valid = 1'b0;
        bus3.cmd_write = 1'b0;
        bus3.cmd_addr  = '0;
        bus3.cmd_wdata = '0;

        #12;
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst_paddr", 32'(bus.paddr), 32'd0);
        chk("rst_pwdata", 32'(bus.pwdata), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (2) @(negedge pclk);
        preset = 1'b1;

        // wr, addr, wdata, waits, pslverr, slave data, push, exp rdata, exp err, exp latency
        issue(1'b1, 9'd5,   8'd69,  0, 1'b0, 8'h00, 1'b1, 8'd0,   1'b0, 3);
        issue(1'b0, 9'd5,   8'hEE,  0, 1'b0, 8'h00, 1'b1, 8'd69,  1'b0, 3);
        repeat (3) @(negedge pclk);
        chk("rsp_rdata_hold", 32'(bus.rsp_rdata), 32'd69);
        issue(1'b0, 9'd269, 8'h00,  3, 1'b0, 8'd121, 1'b1, 8'd121, 1'b0, 6);
        issue(1'b1, 9'd310, 8'h3C,  0, 1'b1, 8'h99, 1'b1, 8'd0,   1'b1, 3);
        issue(1'b0, 9'd300, 8'h00,  2, 1'b1, 8'hAB, 1'b1, 8'd0,   1'b1, 5);
        issue(1'b0, 9'd7,   8'h00,  1, 1'b0, 8'h4D, 1'b1, 8'h4D,  1'b0, 4);

        // Abort a stalled ACCESS with an asynchronous reset.
        issue(1'b0, 9'd260, 8'h00, 1000, 1'b0, 8'h42, 1'b0, 8'd0, 1'b0, 0);
        guard = 0;
        while (!bus.penable && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        chk("stall_penable", 32'(bus.penable), 32'd1);
        @(negedge pclk);
        #2 preset = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.psel), 32'd0);
        chk("arst_penable", 32'(bus.penable), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b1;
        issue(1'b0, 9'd5,   8'h00,  1, 1'b0, 8'h00, 1'b1, 8'd69,  1'b0, 4);

        // Decode error on the 3-slave instance: idx 3 has no slave.
        @(negedge pclk);
        bus3.cmd_valid = 1'b1;
        bus3.cmd_write = 1'b0;
        bus3.cmd_addr  = 10'h3F0;
        dec_active     = 1'b1;
        chk("dec_cmd_ready", 32'(bus3.cmd_ready), 32'd1);
        sb3.push_back('{rd: 8'd0, err: 1'b1, lat: 1, t: cyc + 1});
        @(posedge pclk);
        #1 bus3.cmd_valid = 1'b0;
        guard = 0;
        while (sb3.size() != 0 && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        if (sb3.size() != 0) begin
            total++;
            bad++;
            $display("FAIL dec_rsp_timeout: got no rsp_valid expected one within 20 cycles");
            sb3.delete();
        end
        repeat (2) @(negedge pclk);
        dec_active = 1'b0;

`ifdef APB_TIMEOUT_EN
        issue(1'b0, 9'd20,  8'h00, 100, 1'b0, 8'h77, 1'b1, 8'd0,   1'b1, 6);
        issue(1'b0, 9'd21,  8'h00,  3,  1'b0, 8'h66, 1'b1, 8'h66,  1'b0, 6);
        issue(1'b1, 9'd280, 8'h12, 100, 1'b0, 8'h00, 1'b1, 8'd0,   1'b1, 6);
`endif

        repeat (3) @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_nslave.md
Name: apb_master_nslave

Overview:
- Parametrised APB3 master bridge. Converts a single-beat command/response handshake into APB SETUP/ACCESS transfers to NUM_SLAVES slaves.
- Generalises the existing two-slave, 9-bit-address, 8-bit-data APB block with:
  - configurable address width, data width and slave count,
  - PREADY wait states,
  - PSLVERR and decode-error reporting.
- Sits between the system command source and the APB slave fabric.

Parameters:
- ADDR_W, 9: command/PADDR width.
- DATA_W, 8: PWDATA/PRDATA width.
- NUM_SLAVES, 2: number of slaves (2..16). SEL_W = $clog2(NUM_SLAVES).
- TIMEOUT, 16: ACCESS-phase wait limit in pclk cycles. Used only with APB_TIMEOUT_EN.

Ports:
- pclk, in, 1: APB clock; all logic on posedge.
- preset, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: master can accept a command; high only in IDLE.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: target address; top SEL_W bits select the slave.
- cmd_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: single-cycle completion pulse.
- rsp_rdata, out, DATA_W: read data; 0 for writes and errors.
- rsp_err, out, 1: PSLVERR, decode error or timeout; valid with rsp_valid.
- psel, out, NUM_SLAVES: one-hot slave select.
- penable, out, 1: ACCESS phase.
- pwrite, out, 1: transfer direction.
- paddr, out, ADDR_W: transfer address.
- pwdata, out, DATA_W: write data.
- prdata, in, NUM_SLAVES*DATA_W: flattened read data; slave i occupies bits [i*DATA_W +: DATA_W].
- pready, in, NUM_SLAVES: per-slave ready.
- pslverr, in, NUM_SLAVES: per-slave error.

Behaviour:
- Reset (preset low, asynchronous):
  - state = IDLE.
  - psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Reset mid-transfer aborts immediately; no response is issued for that command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register cmd_write, cmd_addr, cmd_wdata into pwrite/paddr/pwdata. Decode idx = cmd_addr[ADDR_W-1 -: SEL_W].
  - If idx < NUM_SLAVES: go to SETUP. Otherwise (decode error): go to RESP with err = 1; no psel is asserted.
- SETUP (exactly 1 cycle): psel[idx] = 1, penable = 0. Next state is ACCESS.
- ACCESS:
  - psel[idx] = 1, penable = 1.
  - Each cycle, sample pready[idx]. When it is 1: capture prdata slice idx (reads only; writes capture 0) and pslverr[idx], then go to RESP.
  - When pready[idx] is 0: hold every APB output stable. This covers unlimited wait states unless APB_TIMEOUT_EN is defined.
- RESP (1 cycle):
  - psel = 0, penable = 0.
  - rsp_valid = 1 with the captured rsp_rdata/rsp_err.
  - Next state is IDLE.
- rsp_rdata/rsp_err hold their last value between pulses. rsp_rdata = 0 whenever rsp_err = 1.
- Latency:
  - Command accepted at edge T: SETUP T+1, ACCESS T+2.
  - Zero-wait slave: rsp_valid at T+3. Each wait state adds 1 cycle.
  - Decode error: rsp_valid at T+1.
- Throughput: minimum 4 cycles per command. cmd_ready is low from SETUP through RESP, so cmd_valid held high during that time is not accepted until IDLE.
- pready/pslverr/prdata of unselected slaves are ignored. pslverr is sampled only in the completing ACCESS cycle.
- APB outputs are registered; no combinational path from cmd_* to the APB outputs.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on SETUP and increments each ACCESS cycle with pready[idx] = 0.
  - When the count reaches TIMEOUT, the transfer is abandoned: go to RESP with rsp_err = 1, rsp_rdata = 0, and psel/penable drop in that RESP cycle.
  - pready arriving in the same cycle the count reaches TIMEOUT wins and completes the transfer normally.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_nslave_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP),
  - default width constants,
  - the function sel_idx(addr) and the onehot(idx) helper.
- One sub-module, apb_slave_mux: a combinational NUM_SLAVES:1 selector for prdata/pready/pslverr, indexed by idx. All sequential logic stays in the top.

Test Plan:
- Zero-wait write then read, NUM_SLAVES = 2, ADDR_W = 9:
  - write 9'd5 = 8'd69, then read 9'd5.
  - Expect psel = 2'b01, SETUP then ACCESS, rsp_valid at T+3, read rsp_rdata = 69, rsp_err = 0.
- Slave 1 with 3 wait states:
  - read 9'd269 with pready low for 3 cycles, slave data 8'd121.
  - Expect psel = 2'b10, paddr/pwrite/penable stable for 4 ACCESS cycles, rsp_valid at T+6, rsp_rdata = 121.
- PSLVERR:
  - write 9'd310 with pslverr = 1 in the ready cycle.
  - Expect rsp_err = 1, rsp_rdata = 0, FSM back in IDLE with cmd_ready = 1 the next cycle.
- Decode error, NUM_SLAVES = 3, ADDR_W = 10:
  - read 10'h3F0 (idx = 3).
  - Expect no psel bit ever set, rsp_valid at T+1, rsp_err = 1.
- Reset mid-ACCESS:
  - deassert preset while penable = 1.
  - Expect psel = 0 and penable = 0 immediately (asynchronous), no rsp_valid, and the next command completes normally after reset release.
- APB_TIMEOUT_EN with TIMEOUT = 4 and pready stuck low:
  - Expect rsp_err = 1 after 4 ACCESS cycles.
  - Repeat with pready rising on the 4th cycle: expect a normal completion with rsp_err = 0.
